// File: rtl/svc_err_cnt_display.sv
// Per-channel error event counters with a registered display mux.
// The shown channel is either selected manually or rotated on a dwell timer.
module svc_err_cnt_display #(
  parameter int NUM_CH       = 2,
  parameter int CNT_WIDTH    = 16,
  parameter int OUT_WIDTH    = 16,
  parameter bit SATURATE     = 1'b1,
  parameter int DWELL_CYCLES = 25000000,
  localparam int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    err_i,
  input  logic                 clr_i,
  input  logic                 auto_i,
  input  logic [SEL_W-1:0]     sel_i,
  output logic [OUT_WIDTH-1:0] disp_o,
  output logic [SEL_W-1:0]     disp_ch_o,
  output logic [NUM_CH-1:0]    ovf_o,
  output logic                 any_err_o
);

  localparam int                   DW_W       = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [SEL_W-1:0]     LAST_CH    = SEL_W'(NUM_CH - 1);
  localparam logic [DW_W-1:0]      DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [CNT_WIDTH-1:0]   cnt_r [NUM_CH];
  logic [NUM_CH-1:0]      ovf_r;
  logic                   any_err_r;
  logic [SEL_W-1:0]       ch_r, ch_nxt_s, sel_clamp_s;
  logic [DW_W-1:0]        dwell_r, dwell_nxt_s;
  logic [OUT_WIDTH-1:0]   disp_r, disp_nxt_s;
  logic [CNT_WIDTH-1:0]   cnt_shown_s;

  // Counter bank, sticky overflow flags and the any-error flag
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_r[k] <= {CNT_WIDTH{1'b0}};
      end
      ovf_r     <= {NUM_CH{1'b0}};
      any_err_r <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (err_i[k]) begin
          if (cnt_r[k] == CNT_MAX) begin
            ovf_r[k] <= 1'b1;
            cnt_r[k] <= SATURATE ? CNT_MAX : {CNT_WIDTH{1'b0}};
          end else begin
            cnt_r[k] <= cnt_r[k] + CNT_WIDTH'(1);
          end
        end
      end
      if (|err_i) begin
        any_err_r <= 1'b1;
      end
    end
  end

  // Out-of-range selects only exist when NUM_CH is not a power of two
  if ((1 << SEL_W) > NUM_CH) begin : g_sel_clamp
    assign sel_clamp_s = (sel_i > LAST_CH) ? LAST_CH : sel_i;
  end else begin : g_sel_direct
    assign sel_clamp_s = sel_i;
  end

  // Next-state, next-channel and dwell timer logic
  always_comb begin
    state_nxt_s = state_r;
    ch_nxt_s    = ch_r;
    dwell_nxt_s = dwell_r;
    case (state_r)
      ST_MANUAL: begin
        dwell_nxt_s = {DW_W{1'b0}};
        if (auto_i) begin
          state_nxt_s = ST_AUTO;
        end else begin
          ch_nxt_s = sel_clamp_s;
        end
      end
      ST_AUTO: begin
        if (!auto_i) begin
          state_nxt_s = ST_MANUAL;
          ch_nxt_s    = sel_clamp_s;
          dwell_nxt_s = {DW_W{1'b0}};
        end else if (dwell_r == DWELL_LAST) begin
          dwell_nxt_s = {DW_W{1'b0}};
          ch_nxt_s    = (ch_r == LAST_CH) ? {SEL_W{1'b0}} : ch_r + SEL_W'(1);
        end else begin
          dwell_nxt_s = dwell_r + DW_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_MANUAL;
        ch_nxt_s    = sel_clamp_s;
        dwell_nxt_s = {DW_W{1'b0}};
      end
    endcase
  end

  // Counter of the currently registered channel
  always_comb begin
    cnt_shown_s = {CNT_WIDTH{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_shown_s = cnt_shown_s | ((ch_r == SEL_W'(k)) ? cnt_r[k] : {CNT_WIDTH{1'b0}});
    end
  end

  // Values too wide for the display bus show as all-ones
  if (OUT_WIDTH == CNT_WIDTH) begin : g_disp_copy
    assign disp_nxt_s = cnt_shown_s;
  end else begin : g_disp_clamp
    assign disp_nxt_s = (|cnt_shown_s[CNT_WIDTH-1:OUT_WIDTH]) ? {OUT_WIDTH{1'b1}}
                                                              : cnt_shown_s[OUT_WIDTH-1:0];
  end

  // Selection state and display register; clear leaves these untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_MANUAL;
      ch_r    <= {SEL_W{1'b0}};
      dwell_r <= {DW_W{1'b0}};
      disp_r  <= {OUT_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      ch_r    <= ch_nxt_s;
      dwell_r <= dwell_nxt_s;
      disp_r  <= disp_nxt_s;
    end
  end

  assign disp_o    = disp_r;
  assign disp_ch_o = ch_r;
  assign ovf_o     = ovf_r;
  assign any_err_o = any_err_r;

endmodule

// File: tb/tb_svc_err_cnt_display.sv
// Scoreboard bench: a 3-channel clamping instance plus 1-channel wrap/saturate instances.
module tb_svc_err_cnt_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       auto_en = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [2:0] err_a = 3'd0;
  logic       err_bc = 1'b0;
  logic       sel_bc = 1'b0;

  logic [3:0] disp_a, disp_b, disp_c;
  logic [1:0] ch_a;
  logic [0:0] ch_b, ch_c;
  logic [2:0] ovf_a;
  logic [0:0] ovf_b, ovf_c;
  logic       any_a, any_b, any_c;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    string      name;
    int         inst;
    int         due;
    logic [3:0] mask;   // bit0 disp, bit1 channel, bit2 ovf, bit3 any_err
    int         disp;
    int         ch;
    int         ovf;
    int         any_e;
  } exp_t;

  exp_t sb_q[$];

  svc_err_cnt_display #(.NUM_CH(3), .CNT_WIDTH(8), .OUT_WIDTH(4), .SATURATE(1'b1), .DWELL_CYCLES(4)) u_a (
    .clk(clk), .rst(rst), .err_i(err_a), .clr_i(clr), .auto_i(auto_en), .sel_i(sel),
    .disp_o(disp_a), .disp_ch_o(ch_a), .ovf_o(ovf_a), .any_err_o(any_a));

  svc_err_cnt_display #(.NUM_CH(1), .CNT_WIDTH(4), .OUT_WIDTH(4), .SATURATE(1'b0), .DWELL_CYCLES(1)) u_b (
    .clk(clk), .rst(rst), .err_i(err_bc), .clr_i(clr), .auto_i(auto_en), .sel_i(sel_bc),
    .disp_o(disp_b), .disp_ch_o(ch_b), .ovf_o(ovf_b), .any_err_o(any_b));

  svc_err_cnt_display #(.NUM_CH(1), .CNT_WIDTH(4), .OUT_WIDTH(4), .SATURATE(1'b1), .DWELL_CYCLES(1)) u_c (
    .clk(clk), .rst(rst), .err_i(err_bc), .clr_i(clr), .auto_i(auto_en), .sel_i(sel_bc),
    .disp_o(disp_c), .disp_ch_o(ch_c), .ovf_o(ovf_c), .any_err_o(any_c));

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(string nm, int inst, logic [3:0] m, int d, int c, int o, int a);
    exp_t e;
    e.name = nm; e.inst = inst; e.due = cyc; e.mask = m;
    e.disp = d; e.ch = c; e.ovf = o; e.any_e = a;
    sb_q.push_back(e);
  endtask

  task automatic ea(string nm, logic [3:0] m, int d, int c, int o, int a);
    push(nm, 0, m, d, c, o, a);
  endtask

  task automatic eb(string nm, logic [3:0] m, int d, int c, int o, int a);
    push(nm, 1, m, d, c, o, a);
  endtask

  task automatic ec(string nm, logic [3:0] m, int d, int c, int o, int a);
    push(nm, 2, m, d, c, o, a);
  endtask

  task automatic cmp(string nm, string fld, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s.%s actual=%0d expected=%0d", nm, fld, act, expv);
    end
  endtask

  // Monitor: pops every expectation due this cycle and compares on the falling edge
  initial begin
    exp_t        mon_e;
    logic [31:0] a_disp, a_ch, a_ovf, a_any;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        mon_e = sb_q.pop_front();
        case (mon_e.inst)
          0: begin a_disp = 32'(disp_a); a_ch = 32'(ch_a); a_ovf = 32'(ovf_a); a_any = 32'(any_a); end
          1: begin a_disp = 32'(disp_b); a_ch = 32'(ch_b); a_ovf = 32'(ovf_b); a_any = 32'(any_b); end
          default: begin a_disp = 32'(disp_c); a_ch = 32'(ch_c); a_ovf = 32'(ovf_c); a_any = 32'(any_c); end
        endcase
        if (mon_e.mask[0]) cmp(mon_e.name, "disp", a_disp, 32'(mon_e.disp));
        if (mon_e.mask[1]) cmp(mon_e.name, "ch", a_ch, 32'(mon_e.ch));
        if (mon_e.mask[2]) cmp(mon_e.name, "ovf", a_ovf, 32'(mon_e.ovf));
        if (mon_e.mask[3]) cmp(mon_e.name, "any_err", a_any, 32'(mon_e.any_e));
      end
    end
  end

  initial begin
    int rot_exp[10] = '{2, 2, 2, 2, 0, 0, 0, 0, 1, 1};
    int rst_rot_exp[5] = '{0, 0, 0, 0, 1};

    tick(); tick();
    ea("rst_a", 4'hF, 0, 0, 0, 0);
    eb("rst_b", 4'hF, 0, 0, 0, 0);
    ec("rst_c", 4'hF, 0, 0, 0, 0);
    rst = 1'b0;

    // Basic count on channel 1, then switch to channel 0
    sel = 2'd1; tick();
    err_a = 3'b010; repeat (5) tick(); err_a = 3'b000; tick();
    ea("cnt5", 4'hF, 5, 1, 0, 1);
    sel = 2'd0; tick();
    ea("sw_latency", 4'h3, 5, 0, 0, 0);
    tick();
    ea("sw_ch0", 4'h3, 0, 0, 0, 0);

    // Wrap (u_b) versus saturate (u_c) on a 4-bit counter
    err_bc = 1'b1; repeat (15) tick();
    eb("b_pre_ovf", 4'h5, 14, 0, 0, 0);
    ec("c_pre_ovf", 4'h5, 14, 0, 0, 0);
    tick();
    eb("b_at_max", 4'h5, 15, 0, 1, 0);
    ec("c_at_max", 4'h5, 15, 0, 1, 0);
    repeat (4) tick(); err_bc = 1'b0; tick();
    eb("b_wrap20", 4'hD, 4, 0, 1, 1);
    ec("c_sat20", 4'hD, 15, 0, 1, 1);

    // Display clamp on channel 2
    sel = 2'd2; tick();
    err_a = 3'b100; repeat (9) tick(); err_a = 3'b000; tick();
    ea("clamp9", 4'h3, 9, 2, 0, 0);
    err_a = 3'b100; repeat (7) tick(); err_a = 3'b000; tick();
    ea("clamp16", 4'h7, 15, 2, 0, 0);

    // Clear wins over a simultaneous error strobe
    sel = 2'd0; tick();
    err_a = 3'b001; repeat (7) tick(); err_a = 3'b000; tick();
    ea("pre_clr", 4'hB, 7, 0, 0, 1);
    clr = 1'b1; err_a = 3'b001; err_bc = 1'b1; tick();
    clr = 1'b0; err_a = 3'b000; err_bc = 1'b0; tick();
    ea("clr_a", 4'hF, 0, 0, 0, 0);
    eb("clr_b", 4'hD, 0, 0, 0, 0);
    ec("clr_c", 4'hD, 0, 0, 0, 0);
    err_a = 3'b001; tick(); err_a = 3'b000; tick();
    ea("post_clr", 4'h9, 1, 0, 0, 1);

    // Auto rotation starting from channel 2
    sel = 2'd2; tick();
    auto_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      ea($sformatf("rot%0d", i), 4'h2, 0, rot_exp[i], 0, 0);
    end
    auto_en = 1'b0; tick();
    ea("man_back", 4'h2, 0, 2, 0, 0);

    // Reset in the middle of rotation, then a manual out-of-range select
    sel = 2'd0; tick();
    auto_en = 1'b1; err_a = 3'b111; err_bc = 1'b1;
    repeat (5) tick();
    ea("pre_rst_ch", 4'hA, 0, 1, 0, 1);
    err_a = 3'b000; err_bc = 1'b0;
    rst = 1'b1; tick();
    ea("mid_rst_a", 4'hF, 0, 0, 0, 0);
    eb("mid_rst_b", 4'hF, 0, 0, 0, 0);
    ec("mid_rst_c", 4'hF, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      ea($sformatf("rst_rot%0d", i), 4'h3, 0, rst_rot_exp[i], 0, 0);
    end
    auto_en = 1'b0; sel = 2'd3; sel_bc = 1'b1; tick();
    ea("clamp_sel_a", 4'h2, 0, 2, 0, 0);
    eb("clamp_sel_b", 4'h2, 0, 0, 0, 0);

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
